// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter and drives the instruction-memory fetch port.
// Issues one word-addressed fetch at a time, advances by one word per
// accepted instruction, and steers the PC on branch, jump, jr, exception
// and eret redirects. A redirect that lands while a fetch is outstanding is
// parked in a pending-target register and applied once the fetch returns.
// The instruction returned with that ack is then squashed.
// Also holds the EPC register.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   imem_req       fetch request, stable with imem_addr until imem_ack
//   imem_addr      word address of the request
//   imem_ack       memory returns the instruction this cycle (only while req)
//   fetch_valid    delivered instruction is on the correct path
//   fetch_pc       word address of the delivered instruction
//   stall          downstream cannot take the next instruction
//   br_taken       taken branch, target br_pc + 1 + sext(br_off)
//   br_pc, br_off  PC of the redirecting branch/jump and signed word offset
//   j_taken        j/jal, target {(br_pc+1)[31:26], j_index}
//   j_index        26-bit jump index
//   jr_taken       jr/jalr, target jr_addr
//   jr_addr        register target
//   exc, exc_pc    exception request and the PC to record in epc
//   eret           return from exception, target epc
//   epc            exception PC register
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_pc,
   input  logic [15:0] br_off,
   input  logic        j_taken,
   input  logic [25:0] j_index,
   input  logic        jr_taken,
   input  logic [31:0] jr_addr,
   input  logic        exc,
   input  logic [31:0] exc_pc,
   input  logic        eret,
   output logic [31:0] epc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state, state_d;
   logic [31:0] pc, pc_d;
   logic        pend, pend_d;
   logic [31:0] ptgt, ptgt_d;
   logic [31:0] epc_d;

   logic        redir;
   logic [31:0] tgt;
   logic [31:0] br_pc_inc;

   // -----------------------------------------------------------------------
   // Redirect target selection, exc > eret > jr > j > br.
   // eret reads the current epc, so an exc+eret pair sees the old value,
   // although exc wins anyway.
   // -----------------------------------------------------------------------
   assign br_pc_inc = br_pc + 32'd1;
   assign redir     = exc | eret | jr_taken | j_taken | br_taken;

   // NOTE: every output of a combinational block gets a default first;
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      tgt = br_pc_inc + {{16{br_off[15]}}, br_off};
      if (exc)           tgt = EXC_VECTOR;
      else if (eret)     tgt = epc;
      else if (jr_taken) tgt = jr_addr;
      else if (j_taken)  tgt = {br_pc_inc[31:26], j_index};
   end

   // -----------------------------------------------------------------------
   // Next-state and output logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d     = state;
      pc_d        = pc;
      pend_d      = pend;
      ptgt_d      = ptgt;
      imem_req    = 1'b0;
      fetch_valid = 1'b0;

      unique case (state)
         IDLE: begin
            if (redir) pc_d = tgt;
            // Stall only gates requests after the first delivery.
            state_d = REQ;
         end

         REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               // The returned word is always handed downstream; it is only
               // marked wrong-path if a redirect happened during or at the
               // end of this fetch.
               fetch_valid = !pend && !redir;
               pc_d        = redir ? tgt : (pend ? ptgt : pc + 32'd1);
               pend_d      = 1'b0;
               state_d     = stall ? HOLD : REQ;
            end else if (redir) begin
               // Address must stay stable until ack; remember the newest
               // redirect and apply it once this fetch completes.
               pend_d = 1'b1;
               ptgt_d = tgt;
            end
         end

         HOLD: begin
            if (redir) pc_d = tgt;
            if (!stall) state_d = REQ;
         end

         default: state_d = IDLE;
      endcase
   end

   assign imem_addr = pc;
   assign fetch_pc  = pc;
   assign epc_d     = exc ? exc_pc : epc;

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc    <= RESET_PC;
         pend  <= 1'b0;
         ptgt  <= 32'h0000_0000;
         epc   <= 32'h0000_0000;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         pend  <= pend_d;
         ptgt  <= ptgt_d;
         epc   <= epc_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Inputs are changed 1 time unit after the
// rising edge; outputs are sampled one further time unit later, well clear
// of the next edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_pc;
   logic [15:0] br_off;
   logic        j_taken;
   logic [25:0] j_index;
   logic        jr_taken;
   logic [31:0] jr_addr;
   logic        exc;
   logic [31:0] exc_pc;
   logic        eret;
   logic [31:0] epc;

   int n_checks = 0;
   int n_fail   = 0;

   pc_sequencer #(
      .RESET_PC   (32'h0000_0000),
      .EXC_VECTOR (32'h0000_0020)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_pc       (br_pc),
      .br_off      (br_off),
      .j_taken     (j_taken),
      .j_index     (j_index),
      .jr_taken    (jr_taken),
      .jr_addr     (jr_addr),
      .exc         (exc),
      .exc_pc      (exc_pc),
      .eret        (eret),
      .epc         (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_redir();
      br_taken = 1'b0;
      j_taken  = 1'b0;
      jr_taken = 1'b0;
      exc      = 1'b0;
      eret     = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      imem_ack = 1'b0;
      stall    = 1'b0;
      br_pc    = '0;
      br_off   = '0;
      j_index  = '0;
      jr_addr  = '0;
      exc_pc   = '0;
      clear_redir();

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_req",   {31'd0, imem_req},    32'd0);
      check("rst_valid", {31'd0, fetch_valid}, 32'd0);
      check("rst_fpc",   fetch_pc,             32'h0);
      check("rst_epc",   epc,                  32'h0);

      // ---------------- zero-wait streaming ----------------
      rst      = 1'b0;
      imem_ack = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         settle();
         check("stream_req",   {31'd0, imem_req},    32'd1);
         check("stream_addr",  imem_addr,            i);
         check("stream_valid", {31'd0, fetch_valid}, 32'd1);
         check("stream_fpc",   fetch_pc,             i);
         tick();
      end
      // addr 4,5,6 consumed with ack, now fetching 7
      tick();
      tick();
      tick();

      // ---------------- redirect on non-ack REQ cycle ----------------
      imem_ack = 1'b0;
      br_taken = 1'b1;
      br_pc    = 32'd5;
      br_off   = 16'hFFFD;     // -3 -> target 5+1-3 = 3
      settle();
      check("sq_addr7", imem_addr, 32'd7);
      tick();
      clear_redir();
      settle();
      check("sq_hold_addr", imem_addr, 32'd7);
      tick();
      imem_ack = 1'b1;
      settle();
      check("sq_ack_fpc",   fetch_pc,             32'd7);
      check("sq_ack_valid", {31'd0, fetch_valid}, 32'd0);
      tick();
      settle();
      check("sq_new_addr",  imem_addr,            32'd3);
      check("sq_new_valid", {31'd0, fetch_valid}, 32'd1);
      tick();

      // ---------------- exception on ack cycle, then eret ----------------
      exc    = 1'b1;
      exc_pc = 32'h40;
      settle();
      check("exc_addr4",  imem_addr,            32'd4);
      check("exc_squash", {31'd0, fetch_valid}, 32'd0);
      tick();
      clear_redir();
      settle();
      check("exc_epc",   epc,                  32'h40);
      check("exc_vec",   imem_addr,            32'h20);
      check("exc_valid", {31'd0, fetch_valid}, 32'd1);
      tick();
      eret = 1'b1;
      settle();
      check("eret_at21", imem_addr, 32'h21);
      tick();
      clear_redir();
      settle();
      check("eret_addr",  imem_addr,            32'h40);
      check("eret_valid", {31'd0, fetch_valid}, 32'd1);

      // ---------------- exc and eret together ----------------
      exc    = 1'b1;
      eret   = 1'b1;
      exc_pc = 32'h55;
      tick();
      clear_redir();
      settle();
      check("prio_addr", imem_addr, 32'h20);
      check("prio_epc",  epc,       32'h55);

      // ---------------- jump target ----------------
      j_taken = 1'b1;
      br_pc   = 32'h0400_0010;
      j_index = 26'h000_0100;
      tick();
      clear_redir();
      settle();
      check("jump_addr", imem_addr, 32'h0400_0100);

      // ---------------- jr beats br, lands on 9 ----------------
      jr_taken = 1'b1;
      jr_addr  = 32'd9;
      br_taken = 1'b1;
      br_pc    = 32'd100;
      br_off   = 16'd4;
      tick();
      clear_redir();

      // ---------------- stall ----------------
      stall = 1'b1;
      settle();
      check("stall_addr9",  imem_addr,            32'd9);
      check("stall_valid9", {31'd0, fetch_valid}, 32'd1);
      check("stall_fpc9",   fetch_pc,             32'd9);
      tick();
      imem_ack = 1'b0;
      settle();
      check("hold_req0", {31'd0, imem_req}, 32'd0);
      tick();
      settle();
      check("hold_req1", {31'd0, imem_req}, 32'd0);
      stall    = 1'b0;
      tick();
      imem_ack = 1'b1;
      settle();
      check("resume_req",  {31'd0, imem_req}, 32'd1);
      check("resume_addr", imem_addr,         32'd10);

      // ---------------- 32-bit wrap ----------------
      jr_taken = 1'b1;
      jr_addr  = 32'hFFFF_FFFF;
      tick();
      clear_redir();
      settle();
      check("wrap_top", imem_addr, 32'hFFFF_FFFF);
      tick();
      settle();
      check("wrap_zero", imem_addr, 32'h0);
      tick();

      // ---------------- reset mid-REQ ----------------
      imem_ack = 1'b0;
      settle();
      check("pre_rst_addr", imem_addr, 32'd1);
      rst = 1'b1;
      tick();
      settle();
      check("mid_rst_req",  {31'd0, imem_req}, 32'd0);
      check("mid_rst_addr", imem_addr,         32'h0);
      check("mid_rst_epc",  epc,               32'h0);
      rst      = 1'b0;
      imem_ack = 1'b1;
      tick();
      settle();
      check("post_rst_req",  {31'd0, imem_req}, 32'd1);
      check("post_rst_addr", imem_addr,         32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
